// File: rtl/dac_tx_seq_pkg.sv
// Shared types and widths for the clk1x DAC transmit sequencer.
package dac_tx_seq_pkg;

  localparam int unsigned SPC      = 4;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DATA_W   = SPC * 2 * SAMPLE_W;
  localparam int unsigned FLUSH_W  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StRun   = 2'd2,
    StFlush = 2'd3
  } seq_state_e;

endpackage

// File: rtl/dac_tx_ramp_gen.sv
// Test-pattern ramp source for the DAC sequencer (used when DAC_TX_SEQ_RAMP_EN is defined).
// Lane k of beat n carries I = 4n+k and Q = ~I.
module dac_tx_ramp_gen
  import dac_tx_seq_pkg::*;
(
  input  logic              clk1x,
  input  logic              reset_n_1x,
  input  logic              clear,
  input  logic              advance,
  output logic [DATA_W-1:0] ramp_data
);

  logic [SAMPLE_W-1:0] base_q, base_d;
  logic [SAMPLE_W-1:0] lane_i;

  always_comb begin
    base_d = base_q;
    if (clear) begin
      base_d = '0;
    end else if (advance) begin
      base_d = base_q + SAMPLE_W'(SPC);
    end
  end

  always_ff @(posedge clk1x or negedge reset_n_1x) begin
    if (!reset_n_1x) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end

  always_comb begin
    ramp_data = '0;
    lane_i    = '0;
    for (int k = 0; k < SPC; k++) begin
      lane_i = base_q + SAMPLE_W'(k);
      ramp_data[2*SAMPLE_W*k +: SAMPLE_W]            = lane_i;
      ramp_data[2*SAMPLE_W*k + SAMPLE_W +: SAMPLE_W] = ~lane_i;
    end
  end

endmodule

// File: rtl/dac_tx_sequencer.sv
// clk1x sequencer feeding the 4x2 DAC gearbox: start/prime/run/flush with underrun fill.
// Optional build macro DAC_TX_SEQ_RAMP_EN adds pattern_sel and a ramp test source.
module dac_tx_sequencer
  import dac_tx_seq_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk1x,
  input  logic              reset_n_1x,
  input  logic              start,
  input  logic              stop,
  input  logic              clear_count,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] gbx_data,
  output logic              gbx_valid,
  input  logic              gbx_ready,
`ifdef DAC_TX_SEQ_RAMP_EN
  input  logic              pattern_sel,
`endif
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_count,
  output logic [1:0]        state,
  output logic              running
);

  seq_state_e         state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               underrun_q, underrun_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLUSH_W-1:0] flush_q, flush_d;
  logic               cnt_inc, cnt_clr;
  logic               ramp_sel;
  logic [DATA_W-1:0]  ramp_data;

`ifdef DAC_TX_SEQ_RAMP_EN
  logic ramp_clear, ramp_advance;

  assign ramp_sel     = pattern_sel;
  // Ramp restarts from sample 0 each time RUN is entered.
  assign ramp_clear   = (state_q == StPrime) && !stop && s_tvalid;
  assign ramp_advance = (state_q == StRun) && gbx_ready && pattern_sel;

  dac_tx_ramp_gen u_ramp_gen (
    .clk1x      (clk1x),
    .reset_n_1x (reset_n_1x),
    .clear      (ramp_clear),
    .advance    (ramp_advance),
    .ramp_data  (ramp_data)
  );
`else
  assign ramp_sel  = 1'b0;
  assign ramp_data = '0;
`endif

  always_comb begin
    s_tready = 1'b0;
    unique case (state_q)
      StPrime: s_tready = 1'b1;
      StRun:   s_tready = gbx_ready & ~ramp_sel;
      default: s_tready = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    valid_d    = valid_q;
    underrun_d = 1'b0;
    flush_d    = flush_q;
    cnt_inc    = 1'b0;
    cnt_clr    = clear_count;

    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        data_d  = '0;
        if (start && !stop) begin
          state_d = StPrime;
          cnt_clr = 1'b1;
        end
      end
      StPrime: begin
        if (stop) begin
          state_d = StIdle;
        end else if (s_tvalid) begin
          data_d  = s_tdata;
          valid_d = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // Output register only advances once the gearbox has taken the current beat.
        if (gbx_ready) begin
          valid_d = 1'b1;
          if (ramp_sel) begin
            data_d = ramp_data;
          end else if (s_tvalid) begin
            data_d = s_tdata;
          end else begin
            data_d     = '0;
            underrun_d = 1'b1;
            cnt_inc    = 1'b1;
          end
        end
        if (stop) begin
          state_d = StFlush;
          flush_d = FLUSH_W'(FLUSH_CYCLES);
        end
      end
      StFlush: begin
        if (gbx_ready) begin
          data_d = '0;
          if (flush_q != '0) begin
            valid_d = 1'b1;
            flush_d = flush_q - FLUSH_W'(1);
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk1x or negedge reset_n_1x) begin
    if (!reset_n_1x) begin
      state_q    <= StIdle;
      data_q     <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
    end
  end

  assign gbx_data       = data_q;
  assign gbx_valid      = valid_q;
  assign underrun       = underrun_q;
  assign underrun_count = cnt_q;
  assign state          = state_q;
  assign running        = (state_q == StRun);

endmodule

// File: tb/tb_dac_tx_sequencer.sv
// Self-checking bench for dac_tx_sequencer: vector table, directed corner cases, random vs model.
module tb_dac_tx_sequencer;

  localparam int unsigned FLUSH_N = 4;
  localparam int unsigned CW      = 16;

  logic         clk1x       = 1'b0;
  logic         reset_n_1x  = 1'b1;
  logic         start       = 1'b0;
  logic         stop        = 1'b0;
  logic         clear_count = 1'b0;
  logic [127:0] s_tdata     = '0;
  logic         s_tvalid    = 1'b0;
  logic         gbx_ready   = 1'b0;
  logic         s_tready;
  logic [127:0] gbx_data;
  logic         gbx_valid;
  logic         underrun;
  logic [CW-1:0] underrun_count;
  logic [1:0]   state;
  logic         running;
`ifdef DAC_TX_SEQ_RAMP_EN
  logic         pattern_sel = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_state;
  logic [127:0] m_data;
  bit           m_valid;
  bit           m_und;
  logic [15:0]  m_count;
  int           m_left;
  int           m_ramp_n;
  bit           rdy_seen;

  always #5 clk1x = ~clk1x;

  dac_tx_sequencer #(
    .FLUSH_CYCLES (FLUSH_N),
    .CNT_W        (CW)
  ) dut (
    .clk1x          (clk1x),
    .reset_n_1x     (reset_n_1x),
    .start          (start),
    .stop           (stop),
    .clear_count    (clear_count),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .gbx_data       (gbx_data),
    .gbx_valid      (gbx_valid),
    .gbx_ready      (gbx_ready),
`ifdef DAC_TX_SEQ_RAMP_EN
    .pattern_sel    (pattern_sel),
`endif
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .state          (state),
    .running        (running)
  );

  typedef struct {
    bit        st, sp, clr, tv;
    int        n;
    bit        rdy;
    bit        e_rdy;
    int        e_state;
    bit        e_valid;
    int        e_n;
    bit        e_und;
    int        e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] beat(input int n);
    logic [15:0] v;
    v = 16'(n);
    return {8{v}};
  endfunction

  function automatic logic [127:0] ramp_beat(input int n);
    logic [127:0] r;
    logic [15:0]  i;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      i = 16'(4 * n + k);
      r[32*k +: 16]      = i;
      r[32*k + 16 +: 16] = ~i;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit cur_psel();
    bit p;
    p = 1'b0;
`ifdef DAC_TX_SEQ_RAMP_EN
    p = pattern_sel;
`endif
    return p;
  endfunction

  function automatic bit model_rdy();
    if (m_state == 1) return 1'b1;
    if (m_state == 2) return gbx_ready && !cur_psel();
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_und    = 1'b0;
    m_count  = '0;
    m_left   = 0;
    m_ramp_n = 0;
  endtask

  // Behavioural rules applied once per clock, using the inputs present before the edge.
  task automatic model_step();
    bit clr, inc, psel;
    psel  = cur_psel();
    clr   = clear_count;
    inc   = 1'b0;
    m_und = 1'b0;
    case (m_state)
      0: begin
        m_valid = 1'b0;
        m_data  = '0;
        if (start && !stop) begin
          m_state = 1;
          clr     = 1'b1;
        end
      end
      1: begin
        if (stop) m_state = 0;
        else if (s_tvalid) begin
          m_data   = s_tdata;
          m_valid  = 1'b1;
          m_state  = 2;
          m_ramp_n = 0;
        end
      end
      2: begin
        if (gbx_ready) begin
          m_valid = 1'b1;
          if (psel) begin
            m_data = ramp_beat(m_ramp_n);
            m_ramp_n++;
          end else if (s_tvalid) begin
            m_data = s_tdata;
          end else begin
            m_data = '0;
            m_und  = 1'b1;
            inc    = 1'b1;
          end
        end
        if (stop) begin
          m_state = 3;
          m_left  = FLUSH_N;
        end
      end
      default: begin
        if (gbx_ready) begin
          m_data = '0;
          if (m_left > 0) begin
            m_valid = 1'b1;
            m_left--;
          end else begin
            m_valid = 1'b0;
            m_state = 0;
          end
        end
      end
    endcase
    if (clr) m_count = '0;
    else if (inc && m_count != 16'hFFFF) m_count = m_count + 16'd1;
  endtask

  task automatic tick();
    @(negedge clk1x);
    rdy_seen = s_tready;
    chk("s_tready", 128'(s_tready), 128'(model_rdy()));
    model_step();
    @(posedge clk1x);
    #1;
    chk("state", 128'(state), 128'(m_state));
    chk("gbx_valid", 128'(gbx_valid), 128'(m_valid));
    chk("gbx_data", gbx_data, m_data);
    chk("underrun", 128'(underrun), 128'(m_und));
    chk("underrun_count", 128'(underrun_count), 128'(m_count));
    chk("running", 128'(running), 128'(m_state == 2));
  endtask

  task automatic drive(input bit st, input bit sp, input bit clr, input bit tv,
                       input logic [127:0] d, input bit rdy);
    start       = st;
    stop        = sp;
    clear_count = clr;
    s_tvalid    = tv;
    s_tdata     = d;
    gbx_ready   = rdy;
  endtask

  task automatic add(input bit st, sp, clr, tv, input int n, input bit rdy, e_rdy,
                     input int e_state, input bit e_valid, input int e_n, input bit e_und,
                     input int e_cnt);
    vec_t v;
    v.st = st; v.sp = sp; v.clr = clr; v.tv = tv; v.n = n; v.rdy = rdy;
    v.e_rdy = e_rdy; v.e_state = e_state; v.e_valid = e_valid; v.e_n = e_n;
    v.e_und = e_und; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  initial begin
    model_reset();
    rdy_seen = 1'b0;
    #2 reset_n_1x = 1'b0;
    repeat (2) @(posedge clk1x);
    #1 reset_n_1x = 1'b1;
    chk("rst_state", 128'(state), 128'(0));
    chk("rst_valid", 128'(gbx_valid), 128'(0));
    chk("rst_data", gbx_data, 128'(0));
    chk("rst_count", 128'(underrun_count), 128'(0));

    //   st sp cl tv  n rdy | rdy st v  n u cnt
    add(1, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1,   1, 2, 1, 1, 0, 0);
    add(0, 0, 0, 1, 2, 1,   1, 2, 1, 2, 0, 0);
    add(0, 0, 0, 1, 3, 1,   1, 2, 1, 3, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 2, 1, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1,   1, 2, 1, 0, 1, 2);
    add(0, 0, 0, 0, 0, 1,   1, 2, 1, 0, 1, 3);
    add(0, 0, 1, 1, 4, 1,   1, 2, 1, 4, 0, 0);
    add(0, 1, 0, 1, 5, 1,   1, 3, 1, 5, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 3, 1, 0, 0, 0);
    add(0, 0, 0, 1, 6, 0,   0, 3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 3, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1,   0, 3, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1,   0, 3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].sp, vecs[i].clr, vecs[i].tv, beat(vecs[i].n), vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d_rdy", i), 128'(rdy_seen), 128'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_state", i), 128'(state), 128'(vecs[i].e_state));
      chk($sformatf("vec%0d_valid", i), 128'(gbx_valid), 128'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i), gbx_data, beat(vecs[i].e_n));
      chk($sformatf("vec%0d_und", i), 128'(underrun), 128'(vecs[i].e_und));
      chk($sformatf("vec%0d_cnt", i), 128'(underrun_count), 128'(vecs[i].e_cnt));
    end

    // Stop in PRIME discards the beat offered in the same cycle.
    drive(1, 0, 0, 0, '0, 1); tick();
    drive(0, 1, 0, 1, beat(9), 1); tick();
    chk("prime_stop_state", 128'(state), 128'(0));
    chk("prime_stop_valid", 128'(gbx_valid), 128'(0));
    chk("prime_stop_data", gbx_data, 128'(0));

    // Counter saturation and clear-over-increment.
    drive(1, 0, 0, 0, '0, 1); tick();
    drive(0, 0, 0, 1, beat(1), 1); tick();
    drive(0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_fffe", 128'(underrun_count), 128'(16'hFFFE));
    tick();
    chk("sat_ffff", 128'(underrun_count), 128'(16'hFFFF));
    tick(); tick();
    chk("sat_hold", 128'(underrun_count), 128'(16'hFFFF));
    drive(0, 0, 1, 0, '0, 1); tick();
    chk("clr_vs_inc_cnt", 128'(underrun_count), 128'(0));
    chk("clr_vs_inc_und", 128'(underrun), 128'(1));
    drive(0, 1, 0, 0, '0, 1); tick();
    drive(0, 0, 0, 0, '0, 1);
    for (int i = 0; i < FLUSH_N + 1; i++) tick();
    chk("flush_done_state", 128'(state), 128'(0));

    // Asynchronous reset while running with valid data.
    drive(1, 0, 0, 0, '0, 1); tick();
    drive(0, 0, 0, 1, beat(7), 1); tick();
    drive(0, 0, 0, 0, '0, 1); tick();
    drive(0, 0, 0, 1, beat(8), 1); tick();
    #2 reset_n_1x = 1'b0;
    #1;
    model_reset();
    chk("arst_state", 128'(state), 128'(0));
    chk("arst_valid", 128'(gbx_valid), 128'(0));
    chk("arst_data", gbx_data, 128'(0));
    chk("arst_count", 128'(underrun_count), 128'(0));
    @(posedge clk1x);
    #1 reset_n_1x = 1'b1;

`ifdef DAC_TX_SEQ_RAMP_EN
    drive(1, 0, 0, 0, '0, 1); tick();
    drive(0, 0, 0, 1, beat(3), 1); tick();
    pattern_sel = 1'b1;
    tick();
    chk("ramp_tready", 128'(rdy_seen), 128'(0));
    chk("ramp_b0_l0_i", 128'(gbx_data[15:0]), 128'(16'h0000));
    chk("ramp_b0_l0_q", 128'(gbx_data[31:16]), 128'(16'hFFFF));
    chk("ramp_b0_l3_q", 128'(gbx_data[127:112]), 128'(16'hFFFC));
    tick();
    chk("ramp_b1_l0_i", 128'(gbx_data[15:0]), 128'(16'h0004));
    chk("ramp_b1_l3_i", 128'(gbx_data[111:96]), 128'(16'h0007));
    chk("ramp_cnt", 128'(underrun_count), 128'(0));
    pattern_sel = 1'b0;
    drive(0, 1, 0, 0, '0, 1); tick();
    drive(0, 0, 0, 0, '0, 1);
    for (int i = 0; i < FLUSH_N + 1; i++) tick();
`endif

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 80,
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 99) < 75);
`ifdef DAC_TX_SEQ_RAMP_EN
      pattern_sel = $urandom_range(0, 99) < 15;
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
